// File: rtl/fetch_unit.sv
// Instruction fetch front end: single outstanding I-cache request, IF/ID
// payload with hold buffer for stalls, and squash of redirected requests.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        icache_req_o,
  output logic [31:0] icache_addr_o,
  input  logic        icache_valid_i,
  input  logic [31:0] icache_data_i,
  output logic [31:0] if_inst_o,
  output logic [31:0] if_pc_o,
  output logic        if_valid_o,
  output logic        fetch_wait_o
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] buf_q, buf_d;

  logic [XLEN-1:0] redirect_tgt;
  logic [XLEN-1:0] addr_inc;

  logic            req_c;
  logic            valid_c;
  logic [XLEN-1:0] inst_c;
  logic [XLEN-1:0] pc_out_c;

  // Word-aligned redirect target and sequential successor (wraps mod 2^32)
  assign redirect_tgt = {redirect_pc_i[XLEN-1:2], 2'b00};
  assign addr_inc     = addr_q + XLEN'(4);

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      buf_q   <= NOP;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      buf_q   <= buf_d;
    end
  end

  // Next-state, register updates and IF/ID payload
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    addr_d   = addr_q;
    buf_d    = buf_q;
    req_c    = 1'b0;
    valid_c  = 1'b0;
    inst_c   = NOP;
    pc_out_c = '0;

    case (state_q)
      IDLE: begin
        addr_d  = pc_q;
        state_d = REQ;
      end

      REQ: begin
        req_c = 1'b1;
        if (icache_valid_i) begin
          if (redirect_i) begin
            pc_d   = redirect_tgt;
            addr_d = redirect_tgt;
          end else begin
            valid_c  = 1'b1;
            inst_c   = icache_data_i;
            pc_out_c = addr_q;
            if (stall_i) begin
              buf_d   = icache_data_i;
              state_d = HOLD;
            end else begin
              pc_d   = addr_inc;
              addr_d = addr_inc;
            end
          end
        end else if (redirect_i) begin
          // Request still in flight: remember target, squash its response
          pc_d    = redirect_tgt;
          state_d = DROP;
        end
      end

      HOLD: begin
        if (redirect_i) begin
          pc_d    = redirect_tgt;
          addr_d  = redirect_tgt;
          state_d = REQ;
        end else begin
          valid_c  = 1'b1;
          inst_c   = buf_q;
          pc_out_c = addr_q;
          if (!stall_i) begin
            pc_d    = addr_inc;
            addr_d  = addr_inc;
            state_d = REQ;
          end
        end
      end

      DROP: begin
        req_c = 1'b1;
        if (redirect_i) begin
          pc_d = redirect_tgt;
        end
        if (icache_valid_i) begin
          addr_d  = redirect_i ? redirect_tgt : pc_q;
          state_d = REQ;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (rst) begin
      req_c    = 1'b0;
      valid_c  = 1'b0;
      inst_c   = NOP;
      pc_out_c = '0;
    end
  end

  // Output drive
  assign icache_req_o  = req_c;
  assign icache_addr_o = addr_q;
  assign if_valid_o    = valid_c;
  assign if_inst_o     = inst_c;
  assign if_pc_o       = pc_out_c;
  assign fetch_wait_o  = !valid_c && !rst;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed cycle table plus randomized run against a model.
module tb_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam logic [31:0] NP  = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        icache_req_o;
  logic [31:0] icache_addr_o;
  logic        icache_valid_i;
  logic [31:0] icache_data_i;
  logic [31:0] if_inst_o;
  logic [31:0] if_pc_o;
  logic        if_valid_o;
  logic        fetch_wait_o;

  int pass_cnt  = 0;
  int total_cnt = 0;

  fetch_unit #(.RESET_PC(RPC), .NOP(NP)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .icache_req_o  (icache_req_o),
    .icache_addr_o (icache_addr_o),
    .icache_valid_i(icache_valid_i),
    .icache_data_i (icache_data_i),
    .if_inst_o     (if_inst_o),
    .if_pc_o       (if_pc_o),
    .if_valid_o    (if_valid_o),
    .fetch_wait_o  (fetch_wait_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        valid;
    logic [31:0] data;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_inst;
    logic [31:0] e_pc;
    logic        e_wait;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s @%0d: got %h want %h", name, idx, act, exp);
    else pass_cnt++;
  endtask

  task automatic drive(input logic r, input logic s, input logic rd, input logic [31:0] rp,
                       input logic v, input logic [31:0] d);
    rst = r; stall_i = s; redirect_i = rd; redirect_pc_i = rp;
    icache_valid_i = v; icache_data_i = d;
  endtask

  // Reference model state: phase flags rather than an encoded FSM
  logic        m_idle;
  logic        m_held;
  logic        m_squash;
  logic [31:0] m_next_pc;
  logic [31:0] m_out_addr;
  logic [31:0] m_word;

  initial begin
    logic        e_req, e_valid, e_wait;
    logic [31:0] e_inst, e_pc, tgt;
    logic        r, s, rd, v;
    logic [31:0] rp, d;

    // Directed cycle table (cycle-by-cycle from power-up)
    vecs.push_back('{1'b1,1'b0,1'b0,32'h0,1'b0,32'h0,          1'b0,32'h0,1'b0,NP,32'h0,1'b0});
    vecs.push_back('{1'b1,1'b0,1'b0,32'h0,1'b0,32'h0,          1'b0,32'h0,1'b0,NP,32'h0,1'b0});
    vecs.push_back('{1'b0,1'b0,1'b0,32'h0,1'b1,32'hDEAD0000,   1'b0,32'h0,1'b0,NP,32'h0,1'b1});
    vecs.push_back('{1'b0,1'b0,1'b0,32'h0,1'b1,32'hA0,         1'b1,32'h0,1'b1,32'hA0,32'h0,1'b0});
    vecs.push_back('{1'b0,1'b0,1'b0,32'h0,1'b1,32'hA4,         1'b1,32'h4,1'b1,32'hA4,32'h4,1'b0});
    vecs.push_back('{1'b0,1'b0,1'b0,32'h0,1'b1,32'hA8,         1'b1,32'h8,1'b1,32'hA8,32'h8,1'b0});
    vecs.push_back('{1'b0,1'b0,1'b0,32'h0,1'b1,32'hAC,         1'b1,32'hC,1'b1,32'hAC,32'hC,1'b0});
    vecs.push_back('{1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,          1'b1,32'h10,1'b0,NP,32'h0,1'b1});
    vecs.push_back('{1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,          1'b1,32'h10,1'b0,NP,32'h0,1'b1});
    vecs.push_back('{1'b0,1'b0,1'b0,32'h0,1'b1,32'hB0,         1'b1,32'h10,1'b1,32'hB0,32'h10,1'b0});
    vecs.push_back('{1'b0,1'b1,1'b0,32'h0,1'b1,32'hB4,         1'b1,32'h14,1'b1,32'hB4,32'h14,1'b0});
    vecs.push_back('{1'b0,1'b1,1'b0,32'h0,1'b0,32'h0,          1'b0,32'h0,1'b1,32'hB4,32'h14,1'b0});
    vecs.push_back('{1'b0,1'b1,1'b0,32'h0,1'b0,32'h0,          1'b0,32'h0,1'b1,32'hB4,32'h14,1'b0});
    vecs.push_back('{1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,          1'b0,32'h0,1'b1,32'hB4,32'h14,1'b0});
    vecs.push_back('{1'b0,1'b0,1'b1,32'h41,1'b1,32'hC8,        1'b1,32'h18,1'b0,NP,32'h0,1'b1});
    vecs.push_back('{1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,          1'b1,32'h40,1'b0,NP,32'h0,1'b1});
    vecs.push_back('{1'b0,1'b0,1'b1,32'h2003,1'b0,32'h0,       1'b1,32'h40,1'b0,NP,32'h0,1'b1});
    vecs.push_back('{1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,          1'b1,32'h40,1'b0,NP,32'h0,1'b1});
    vecs.push_back('{1'b0,1'b0,1'b0,32'h0,1'b1,32'hD40,        1'b1,32'h40,1'b0,NP,32'h0,1'b1});
    vecs.push_back('{1'b0,1'b0,1'b0,32'h0,1'b1,32'hE0,         1'b1,32'h2000,1'b1,32'hE0,32'h2000,1'b0});
    vecs.push_back('{1'b0,1'b0,1'b1,32'h3000,1'b0,32'h0,       1'b1,32'h2004,1'b0,NP,32'h0,1'b1});
    vecs.push_back('{1'b1,1'b0,1'b0,32'h0,1'b1,32'hBAD,        1'b0,32'h0,1'b0,NP,32'h0,1'b0});
    vecs.push_back('{1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,          1'b0,32'h0,1'b0,NP,32'h0,1'b1});
    vecs.push_back('{1'b0,1'b0,1'b0,32'h0,1'b1,32'hF0,         1'b1,32'h0,1'b1,32'hF0,32'h0,1'b0});
    vecs.push_back('{1'b0,1'b1,1'b0,32'h0,1'b1,32'hF4,         1'b1,32'h4,1'b1,32'hF4,32'h4,1'b0});
    vecs.push_back('{1'b0,1'b1,1'b1,32'hFFFFFFFE,1'b0,32'h0,   1'b0,32'h0,1'b0,NP,32'h0,1'b1});
    vecs.push_back('{1'b0,1'b0,1'b0,32'h0,1'b1,32'h99,         1'b1,32'hFFFFFFFC,1'b1,32'h99,32'hFFFFFFFC,1'b0});
    vecs.push_back('{1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,          1'b1,32'h0,1'b0,NP,32'h0,1'b1});

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].stall, vecs[i].redir, vecs[i].rpc, vecs[i].valid, vecs[i].data);
      #2;
      chk("tbl_req",   i, 32'(icache_req_o), 32'(vecs[i].e_req));
      if (vecs[i].e_req) chk("tbl_addr", i, icache_addr_o, vecs[i].e_addr);
      chk("tbl_valid", i, 32'(if_valid_o),   32'(vecs[i].e_valid));
      chk("tbl_inst",  i, if_inst_o,         vecs[i].e_inst);
      chk("tbl_pc",    i, if_pc_o,           vecs[i].e_pc);
      chk("tbl_wait",  i, 32'(fetch_wait_o), 32'(vecs[i].e_wait));
      @(posedge clk); #1;
    end

    // Randomized run: reset first, then model tracks every cycle
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    @(posedge clk); #1;
    m_idle = 1'b1; m_held = 1'b0; m_squash = 1'b0;
    m_next_pc = RPC; m_out_addr = RPC; m_word = NP;

    for (int c = 0; c < 3000; c++) begin
      r  = ($urandom_range(63) == 0);
      s  = ($urandom_range(2) == 0);
      rd = ($urandom_range(7) == 0);
      case ($urandom_range(3))
        0:       rp = $urandom();
        1:       rp = 32'hFFFFFFFC | 32'($urandom_range(3));
        default: rp = 32'($urandom_range(255));
      endcase
      d = $urandom();

      // Expected request level from the model decides whether the cache answers
      e_req = !r && !m_idle && !m_held;
      v = e_req && ($urandom_range(1) == 1);
      drive(r, s, rd, rp, v, d);

      e_valid = 1'b0; e_inst = NP; e_pc = 32'h0;
      if (!r && !m_idle) begin
        if (m_held && !rd) begin
          e_valid = 1'b1; e_inst = m_word; e_pc = m_out_addr;
        end else if (!m_held && !m_squash && !rd && v) begin
          e_valid = 1'b1; e_inst = d; e_pc = m_out_addr;
        end
      end
      e_wait = !e_valid && !r;

      #2;
      chk("rnd_req",   c, 32'(icache_req_o), 32'(e_req));
      if (e_req) chk("rnd_addr", c, icache_addr_o, m_out_addr);
      chk("rnd_valid", c, 32'(if_valid_o),   32'(e_valid));
      chk("rnd_inst",  c, if_inst_o,         e_inst);
      chk("rnd_pc",    c, if_pc_o,           e_pc);
      chk("rnd_wait",  c, 32'(fetch_wait_o), 32'(e_wait));

      tgt = rp & 32'hFFFFFFFC;
      if (r) begin
        m_idle = 1'b1; m_held = 1'b0; m_squash = 1'b0;
        m_next_pc = RPC; m_out_addr = RPC;
      end else if (m_idle) begin
        m_idle = 1'b0; m_out_addr = m_next_pc;
      end else if (m_held) begin
        if (rd) begin
          m_held = 1'b0; m_next_pc = tgt; m_out_addr = tgt;
        end else if (!s) begin
          m_held = 1'b0; m_out_addr = m_out_addr + 32'd4; m_next_pc = m_out_addr;
        end
      end else if (m_squash) begin
        if (rd) m_next_pc = tgt;
        if (v) begin
          m_squash = 1'b0; m_out_addr = m_next_pc;
        end
      end else if (v) begin
        if (rd) begin
          m_next_pc = tgt; m_out_addr = tgt;
        end else if (s) begin
          m_held = 1'b1; m_word = d;
        end else begin
          m_out_addr = m_out_addr + 32'd4; m_next_pc = m_out_addr;
        end
      end else if (rd) begin
        m_next_pc = tgt; m_squash = 1'b1;
      end

      @(posedge clk); #1;
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
